// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared state type, default widths and clog2 helper for the data-memory arbiter
package dmem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_RESP  = 2'd2
  } dmem_state_t;

  localparam int DMEM_ADDR_W    = 32;
  localparam int DMEM_DATA_W    = 32;
  localparam int DMEM_MEM_DEPTH = 4096;

  function automatic int clog2(input int n);
    int w;
    w = 0;
    while ((1 << w) < n) begin
      w = w + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin pick: first set request at or above i_ptr, wrapping
module rr_arbiter
  import dmem_pkg::*;
#(
  parameter int N  = 2,
  parameter int PW = clog2(N)
) (
  input  logic [N-1:0]  i_req,
  input  logic [PW-1:0] i_ptr,
  output logic [N-1:0]  o_gnt,
  output logic [PW-1:0] o_idx,
  output logic          o_any
);

  always_comb begin : p_pick
    int j;
    j     = 0;
    o_gnt = '0;
    o_idx = '0;
    o_any = 1'b0;
    for (int off = 0; off < N; off++) begin
      j = (int'(i_ptr) + off) % N;
      if (!o_any && i_req[j]) begin
        o_any    = 1'b1;
        o_gnt[j] = 1'b1;
        o_idx    = PW'(j);
      end
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - round-robin sequencer sharing one data memory among N_REQ requesters
// Optional address bounds check: define DMEM_ARB_BOUNDS_CHECK_EN.
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int N_REQ     = 2,
  parameter int ADDR_W    = DMEM_ADDR_W,
  parameter int DATA_W    = DMEM_DATA_W,
  parameter int MEM_DEPTH = DMEM_MEM_DEPTH
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic [N_REQ-1:0]          req,
  input  logic [N_REQ-1:0]          req_we,
  input  logic [N_REQ*ADDR_W-1:0]   req_addr,
  input  logic [N_REQ*DATA_W-1:0]   req_wdata,
  output logic [N_REQ-1:0]          gnt,
  output logic [N_REQ-1:0]          rsp_valid,
  output logic [DATA_W-1:0]         rsp_rdata,
  output logic [N_REQ-1:0]          rsp_err,
  output logic                      mem_rd,
  output logic                      mem_wr,
  output logic [ADDR_W-1:0]         mem_addr,
  output logic [DATA_W-1:0]         mem_din,
  input  logic [DATA_W-1:0]         mem_dout,
  output logic                      busy
);

  localparam int PTR_W = clog2(N_REQ);

  if (N_REQ < 2 || N_REQ > 8 || MEM_DEPTH < 1) begin : g_bad_param
    $error("dmem_arbiter: N_REQ must be 2..8 and MEM_DEPTH positive");
  end

  dmem_state_t        r_state;
  logic [PTR_W-1:0]   r_ptr;
  logic [PTR_W-1:0]   r_owner;
  logic               r_we;
  logic               r_mem_rd;
  logic               r_mem_wr;
  logic [ADDR_W-1:0]  r_mem_addr;
  logic [DATA_W-1:0]  r_mem_din;
  logic [DATA_W-1:0]  r_rdata_q;
  logic [N_REQ-1:0]   r_rsp_valid;

  logic [N_REQ-1:0]   w_pick;
  logic [PTR_W-1:0]   w_idx;
  logic [PTR_W-1:0]   w_ptr_nxt;
  logic               w_any;
  logic               w_accept;
  logic               w_sel_we;
  logic [ADDR_W-1:0]  w_sel_addr;
  logic [DATA_W-1:0]  w_sel_wdata;
  logic               w_oob;
  logic [DATA_W-1:0]  w_rd_data;
  logic [N_REQ-1:0]   w_owner_oh;

  rr_arbiter #(
    .N  (N_REQ),
    .PW (PTR_W)
  ) u_rr (
    .i_req (req),
    .i_ptr (r_ptr),
    .o_gnt (w_pick),
    .o_idx (w_idx),
    .o_any (w_any)
  );

  // Arbitration is suppressed while resetting so no grant is lost to the reset edge.
  assign w_accept    = !RST && (r_state != ST_ISSUE) && w_any;
  assign w_sel_we    = req_we[w_idx];
  assign w_sel_addr  = req_addr[w_idx*ADDR_W +: ADDR_W];
  assign w_sel_wdata = req_wdata[w_idx*DATA_W +: DATA_W];
  assign w_ptr_nxt   = (w_idx == PTR_W'(N_REQ - 1)) ? '0 : w_idx + 1'b1;
  assign w_owner_oh  = N_REQ'(1) << r_owner;

`ifdef DMEM_ARB_BOUNDS_CHECK_EN
  localparam logic [ADDR_W-1:0] DEPTH_LIM = ADDR_W'(MEM_DEPTH);
  logic             r_oob;
  logic [N_REQ-1:0] r_rsp_err;
  assign w_oob     = w_sel_addr >= DEPTH_LIM;
  assign w_rd_data = r_oob ? '0 : mem_dout;
  assign rsp_err   = r_rsp_err;
`else
  assign w_oob     = 1'b0;
  assign w_rd_data = mem_dout;
  assign rsp_err   = '0;
`endif

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state     <= ST_IDLE;
      r_ptr       <= '0;
      r_owner     <= '0;
      r_we        <= 1'b0;
      r_mem_rd    <= 1'b0;
      r_mem_wr    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_din   <= '0;
      r_rdata_q   <= '0;
      r_rsp_valid <= '0;
`ifdef DMEM_ARB_BOUNDS_CHECK_EN
      r_oob       <= 1'b0;
      r_rsp_err   <= '0;
`endif
    end else begin
      case (r_state)
        ST_ISSUE: begin
          r_mem_rd    <= 1'b0;
          r_mem_wr    <= 1'b0;
          r_rsp_valid <= w_owner_oh;
`ifdef DMEM_ARB_BOUNDS_CHECK_EN
          r_rsp_err   <= r_oob ? w_owner_oh : '0;
`endif
          r_state     <= ST_RESP;
        end
        default: begin
          r_rsp_valid <= '0;
`ifdef DMEM_ARB_BOUNDS_CHECK_EN
          r_rsp_err   <= '0;
`endif
          if (r_state == ST_RESP && !r_we) begin
            r_rdata_q <= w_rd_data;
          end
          if (w_accept) begin
            r_owner    <= w_idx;
            r_ptr      <= w_ptr_nxt;
            r_we       <= w_sel_we;
            r_mem_addr <= w_sel_addr;
            r_mem_din  <= w_sel_wdata;
            r_mem_rd   <= !w_sel_we && !w_oob;
            r_mem_wr   <= w_sel_we && !w_oob;
`ifdef DMEM_ARB_BOUNDS_CHECK_EN
            r_oob      <= w_oob;
`endif
            r_state    <= ST_ISSUE;
          end else begin
            r_state    <= ST_IDLE;
          end
        end
      endcase
    end
  end

  assign gnt       = w_accept ? w_pick : '0;
  assign rsp_valid = r_rsp_valid;
  assign rsp_rdata = (r_state == ST_RESP && !r_we) ? w_rd_data : r_rdata_q;
  assign mem_rd    = r_mem_rd;
  assign mem_wr    = r_mem_wr;
  assign mem_addr  = r_mem_addr;
  assign mem_din   = r_mem_din;
  assign busy      = (r_state != ST_IDLE);

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - directed bench with a cycle-schedule reference model for dmem_arbiter
module tb_dmem_arbiter;

  localparam int N  = 2;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int DEPTH = 4096;

  logic            CLK = 1'b0;
  logic            RST = 1'b1;
  logic [N-1:0]    req = '0;
  logic [N-1:0]    req_we = '0;
  logic [N*AW-1:0] req_addr = '0;
  logic [N*DW-1:0] req_wdata = '0;
  logic [N-1:0]    gnt, rsp_valid, rsp_err;
  logic [DW-1:0]   rsp_rdata;
  logic            mem_rd, mem_wr, busy;
  logic [AW-1:0]   mem_addr;
  logic [DW-1:0]   mem_din;
  logic [DW-1:0]   mem_dout = '0;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  bit chk_en  = 1'b0;
  bit done    = 1'b0;

  dmem_arbiter #(.N_REQ(N), .ADDR_W(AW), .DATA_W(DW), .MEM_DEPTH(DEPTH)) dut (
    .CLK(CLK), .RST(RST), .req(req), .req_we(req_we), .req_addr(req_addr),
    .req_wdata(req_wdata), .gnt(gnt), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_addr(mem_addr),
    .mem_din(mem_din), .mem_dout(mem_dout), .busy(busy)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc++;

  // Single-port memory with registered read data.
  logic [DW-1:0] env_mem [logic [AW-1:0]];
  always @(posedge CLK) begin
    if (mem_wr) env_mem[mem_addr] = mem_din;
    if (mem_rd) mem_dout <= env_mem.exists(mem_addr) ? env_mem[mem_addr] : '0;
  end

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, got, exp, cyc);
    end
  endtask

  // Reference model: an access accepted in cycle t strobes memory in t+1 and answers in t+2.
  logic [DW-1:0] ref_mem [logic [AW-1:0]];
  int            m_ptr = 0, m_next_ok = 0, iss_cyc = -1, rsp_cyc = -1, rsp_id = 0;
  bit            iss_we, iss_oob, rsp_we, rsp_oob;
  logic [AW-1:0] iss_addr;
  logic [DW-1:0] iss_data, rsp_data;
  logic [AW-1:0] m_addr = '0;
  logic [DW-1:0] m_din = '0, m_rdata = '0;

  always @(negedge CLK) begin : model
    logic [N-1:0]  e_gnt, e_rv, e_err;
    bit            e_rd, e_wr, e_busy, we, oob;
    int            win;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    if (chk_en) begin
      e_gnt = '0; e_rv = '0; e_err = '0; e_rd = 0; e_wr = 0; e_busy = 0; win = -1;
      if (iss_cyc == cyc) begin
        e_busy = 1; m_addr = iss_addr; m_din = iss_data;
        e_rd = !iss_we && !iss_oob; e_wr = iss_we && !iss_oob;
      end
      if (rsp_cyc == cyc) begin
        e_busy = 1; e_rv[rsp_id] = 1'b1;
        if (rsp_oob) e_err[rsp_id] = 1'b1;
        if (!rsp_we) m_rdata = rsp_oob ? '0 : rsp_data;
      end
      if (!RST && cyc >= m_next_ok)
        for (int off = 0; off < N; off++)
          if (win < 0 && req[(m_ptr + off) % N]) win = (m_ptr + off) % N;
      if (win >= 0) e_gnt[win] = 1'b1;
      chk("gnt", gnt, e_gnt);
      chk("rsp_valid", rsp_valid, e_rv);
      chk("rsp_err", rsp_err, e_err);
      chk("mem_rd", mem_rd, e_rd);
      chk("mem_wr", mem_wr, e_wr);
      chk("rd_wr_exclusive", mem_rd & mem_wr, 0);
      chk("mem_addr", mem_addr, m_addr);
      chk("mem_din", mem_din, m_din);
      chk("busy", busy, e_busy);
      chk("rsp_rdata", rsp_rdata, m_rdata);
      if (RST) begin
        iss_cyc = -1; rsp_cyc = -1; m_ptr = 0; m_next_ok = cyc + 1;
        m_rdata = '0; m_addr = '0; m_din = '0;
      end else if (win >= 0) begin
        a = req_addr[win*AW +: AW]; d = req_wdata[win*DW +: DW]; we = req_we[win];
`ifdef DMEM_ARB_BOUNDS_CHECK_EN
        oob = (a >= DEPTH);
`else
        oob = 0;
`endif
        iss_cyc = cyc + 1; iss_we = we; iss_addr = a; iss_data = d; iss_oob = oob;
        rsp_cyc = cyc + 2; rsp_id = win; rsp_we = we; rsp_oob = oob;
        rsp_data = ref_mem.exists(a) ? ref_mem[a] : '0;
        if (we && !oob) ref_mem[a] = d;
        m_ptr = (win + 1) % N; m_next_ok = cyc + 2;
      end
    end
  end

  task automatic tick();
    @(posedge CLK); #1;
  endtask

  // Raise req for requester r, wait for its grant, drop req after the grant edge.
  task automatic do_req(input int r, input bit we, input logic [AW-1:0] a,
                        input logic [DW-1:0] d, output int gcyc);
    req_we[r] = we; req_addr[r*AW +: AW] = a; req_wdata[r*DW +: DW] = d; req[r] = 1'b1;
    gcyc = -1;
    for (int k = 0; k < 20; k++) begin
      @(negedge CLK);
      if (gnt[r]) begin gcyc = cyc; break; end
      tick();
    end
    tick();
    req[r] = 1'b0;
    if (gcyc < 0) chk("grant_timeout", 0, 1);
  endtask

  initial begin : stim
    int g, cnt;
    int wins[4], wcyc[4];
    int exp_order[4] = '{0, 1, 0, 1};

    tick(); chk_en = 1'b1;
    tick(); RST = 1'b0;
    @(negedge CLK);
    chk("rst_gnt", gnt, 0); chk("rst_rsp_valid", rsp_valid, 0); chk("rst_busy", busy, 0);
    chk("rst_mem_rd", mem_rd, 0); chk("rst_mem_wr", mem_wr, 0);
    chk("rst_mem_addr", mem_addr, 0); chk("rst_rdata", rsp_rdata, 0);
    tick();

    do_req(0, 1'b1, 32'd5, 32'hDEADBEEF, g);
    @(negedge CLK);
    chk("wr_issue_cycle", cyc, g + 1); chk("wr_mem_wr", mem_wr, 1);
    chk("wr_mem_addr", mem_addr, 5); chk("wr_mem_din", mem_din, 32'hDEADBEEF);
    @(negedge CLK);
    chk("wr_rsp_valid", rsp_valid, 2'b01);
    tick();
    do_req(0, 1'b0, 32'd5, 32'h0, g);
    @(negedge CLK);
    chk("rd_mem_rd", mem_rd, 1);
    @(negedge CLK);
    chk("rd_rsp_cycle", cyc, g + 2); chk("rd_rsp_valid", rsp_valid, 2'b01);
    chk("rd_rdata", rsp_rdata, 32'hDEADBEEF);
    tick(); tick();
    chk("rdata_hold", rsp_rdata, 32'hDEADBEEF);

    // Contention after a fresh reset: rr_ptr starts at 0.
    RST = 1'b1; tick(); tick(); RST = 1'b0;
    req_we = 2'b01;
    req_addr = {32'd9, 32'd9}; req_wdata = {32'h0, 32'hA5};
    req = 2'b11; cnt = 0;
    for (int i = 0; i < 4; i++) begin wins[i] = -1; wcyc[i] = -100; end
    for (int k = 0; k < 16; k++) begin
      @(negedge CLK);
      if (gnt != 0 && cnt < 4) begin
        wins[cnt] = (gnt == 2'b10) ? 1 : 0; wcyc[cnt] = cyc; cnt++;
      end
      if (cnt == 4) break;
      tick();
    end
    tick(); req = '0;
    for (int i = 0; i < 4; i++) chk("cont_order", wins[i], exp_order[i]);
    for (int i = 1; i < 4; i++) chk("cont_spacing", wcyc[i] - wcyc[i-1], 2);
    tick(); tick();

    // Back-to-back: requester 1 re-requests in its own RESP cycle.
    do_req(1, 1'b0, 32'd9, 32'h0, g);
    tick();
    req_we[1] = 1'b1; req_addr[AW +: AW] = 32'd12; req_wdata[DW +: DW] = 32'h77; req[1] = 1'b1;
    @(negedge CLK);
    chk("b2b_cycle", cyc, g + 2); chk("b2b_gnt", gnt, 2'b10);
    chk("b2b_rsp_valid", rsp_valid, 2'b10); chk("b2b_rdata", rsp_rdata, 32'hA5);
    tick(); req[1] = 1'b0;
    @(negedge CLK);
    chk("b2b_busy", busy, 1); chk("b2b_mem_wr", mem_wr, 1);
    tick(); tick(); tick();

    // Reset during ISSUE of a write: memory still written, no response.
    do_req(0, 1'b1, 32'd7, 32'h11, g);
    RST = 1'b1;
    @(negedge CLK);
    chk("rmid_mem_wr", mem_wr, 1);
    tick(); RST = 1'b0;
    @(negedge CLK);
    chk("rmid_no_rsp", rsp_valid, 0); chk("rmid_busy", busy, 0);
    tick();
    do_req(0, 1'b0, 32'd7, 32'h0, g);
    @(negedge CLK); @(negedge CLK);
    chk("rmid_rsp", rsp_valid, 2'b01); chk("rmid_rdata", rsp_rdata, 32'h11);
    tick(); tick();

    // Boundary addresses around MEM_DEPTH.
    do_req(0, 1'b0, 32'd4096, 32'h0, g);
    @(negedge CLK);
    chk("oob_busy", busy, 1); chk("oob_mem_addr", mem_addr, 32'd4096);
`ifdef DMEM_ARB_BOUNDS_CHECK_EN
    chk("oob_mem_rd", mem_rd, 0);
    @(negedge CLK);
    chk("oob_rsp", rsp_valid, 2'b01); chk("oob_err", rsp_err, 2'b01);
    chk("oob_rdata", rsp_rdata, 0);
`else
    chk("oob_mem_rd", mem_rd, 1);
    @(negedge CLK);
    chk("oob_rsp", rsp_valid, 2'b01); chk("oob_err", rsp_err, 0);
`endif
    tick();
    do_req(0, 1'b1, 32'd4095, 32'h5A, g);
    @(negedge CLK);
    chk("edge_mem_wr", mem_wr, 1);
    tick();
    do_req(0, 1'b0, 32'd4095, 32'h0, g);
    @(negedge CLK); @(negedge CLK);
    chk("edge_rsp", rsp_valid, 2'b01); chk("edge_err", rsp_err, 0);
    chk("edge_rdata", rsp_rdata, 32'h5A);
    tick(); tick();

    done = 1'b1;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin : watchdog
    #100000;
    if (!done) begin
      n_fail++;
      $display("FAIL watchdog: got timeout expected completion");
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
    end
  end

endmodule
